ram_burst_model: RTL and testbench

Parametrised behavioural memory model for simulating the DDR side of the AXI DDR controller. It replaces the single inout 64-bit bus with separate write and read channels. Each channel has its own burst length and INCR or WRAP addressing, the write channel has byte strobes, and the read path has a configurable latency pipeline. The block is simulation-only and sits under the controller testbench in place of the DDR PHY/MIG.

---
 rtl/ram_burst_model_if.sv | 42 ++++
 rtl/ram_burst_model.sv | 193 +++++++++++++++++++
 tb/tb_ram_burst_model.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_model_if.sv
// Write/read burst channels between the controller side and the DDR memory model.
interface ram_burst_model_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 30
);
  localparam int BYTES = DATA_WIDTH / 8;

  // Write channel
  logic                  wr_start;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len;
  logic                  wr_wrap;
  logic                  wr_data_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]      wr_strb;
  logic                  wr_ready;
  logic                  wr_done;

  // Read channel
  logic                  rd_start;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_len;
  logic                  rd_wrap;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  rd_busy;

  modport master (
    output wr_start, wr_addr, wr_len, wr_wrap, wr_data_valid, wr_data, wr_strb,
    input  wr_ready, wr_done,
    output rd_start, rd_addr, rd_len, rd_wrap,
    input  rd_data, rd_valid, rd_last, rd_busy
  );

  modport slave (
    input  wr_start, wr_addr, wr_len, wr_wrap, wr_data_valid, wr_data, wr_strb,
    output wr_ready, wr_done,
    input  rd_start, rd_addr, rd_len, rd_wrap,
    output rd_data, rd_valid, rd_last, rd_busy
  );
endinterface

// File: rtl/ram_burst_model.sv
// Behavioural DDR-side memory model: independent INCR/WRAP write and read burst
// channels over a byte array, big-endian lanes, byte strobes on writes and a
// fixed-depth read latency pipeline.
module ram_burst_model #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 30,
  parameter int MEM_BYTES  = 8192,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_burst_model_if.slave  bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int MW    = $clog2(MEM_BYTES);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [MW-1:0]         midx_t;

  typedef enum logic {W_IDLE, W_DATA}  w_state_t;
  typedef enum logic {R_IDLE, R_ISSUE} r_state_t;

  // Byte storage; deliberately not reset so contents survive a reset.
  logic [7:0] r_mem [MEM_BYTES];

  w_state_t   r_wr_state, w_wr_next;
  addr_t      r_wr_addr;
  logic [7:0] r_wr_len, r_wr_cnt;
  logic       r_wr_wrap, r_wr_done;
  logic       w_wr_ready, w_wr_accept, w_wr_last;
  midx_t      w_wr_beat;

  r_state_t   r_rd_state, w_rd_next;
  addr_t      r_rd_addr;
  logic [7:0] r_rd_len, r_rd_cnt;
  logic       r_rd_wrap;
  logic       w_rd_issue, w_rd_issue_last, w_rd_busy, w_rd_accept;
  midx_t      w_rd_beat;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic [RD_LATENCY-1:0] r_pv, r_pl;
  logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];

  // Byte index of beat k: aligned start, then WRAP inside a (len+1)*BYTES window
  // for len+1 in {2,4,8,16}, otherwise INCR; finally reduced modulo MEM_BYTES.
  function automatic midx_t f_beat_addr(input addr_t start, input logic [7:0] len,
                                        input logic wrap, input logic [7:0] k);
    addr_t a, w, base, off, step;
    a    = start & ~addr_t'(BYTES - 1);
    step = addr_t'(32'(k) * BYTES);
    if (wrap && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      w    = addr_t'((32'(len) + 32'd1) * BYTES);
      base = a & ~(w - addr_t'(1));
      off  = (a - base + step) & (w - addr_t'(1));
      a    = base + off;
    end else begin
      a = a + step;
    end
    return a[MW-1:0];
  endfunction

  // ---------------- write channel ----------------

  // Write state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_state <= W_IDLE;
    else        r_wr_state <= w_wr_next;
  end

  // Write next-state: leave W_DATA once beat len is accepted
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (bus.wr_start) w_wr_next = W_DATA;
      W_DATA:  if (w_wr_accept && w_wr_last) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Write outputs and beat acceptance
  always_comb begin
    w_wr_ready  = (r_wr_state == W_DATA);
    w_wr_accept = w_wr_ready & bus.wr_data_valid;
    w_wr_last   = (r_wr_cnt == r_wr_len);
  end

  // Write request latch, beat counter and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_wr_len  <= '0;
      r_wr_wrap <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= w_wr_accept & w_wr_last;
      if (r_wr_state == W_IDLE && bus.wr_start) begin
        r_wr_addr <= bus.wr_addr;
        r_wr_len  <= bus.wr_len;
        r_wr_wrap <= bus.wr_wrap;
        r_wr_cnt  <= '0;
      end else if (w_wr_accept) begin
        r_wr_cnt <= r_wr_cnt + 8'd1;
      end
    end
  end

  assign w_wr_beat   = f_beat_addr(r_wr_addr, r_wr_len, r_wr_wrap, r_wr_cnt);
  assign bus.wr_ready = w_wr_ready;
  assign bus.wr_done  = r_wr_done;

  // Strobed byte writes, lane j to beat_addr + BYTES-1-j (big-endian)
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      for (int unsigned j = 0; j < BYTES; j++) begin
        if (bus.wr_strb[j]) r_mem[w_wr_beat + midx_t'(BYTES - 1 - j)] <= bus.wr_data[8*j +: 8];
      end
    end
  end

  // ---------------- read channel ----------------

  // Read state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_state <= R_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  // Read next-state: one beat issued per cycle, no backpressure
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_rd_accept) w_rd_next = R_ISSUE;
      R_ISSUE: if (w_rd_issue_last) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Read outputs; busy covers beats still in flight in the pipeline
  always_comb begin
    w_rd_issue      = (r_rd_state == R_ISSUE);
    w_rd_issue_last = w_rd_issue && (r_rd_cnt == r_rd_len);
    w_rd_busy       = w_rd_issue || (|r_pv);
    w_rd_accept     = (r_rd_state == R_IDLE) && !w_rd_busy && bus.rd_start;
  end

  // Read request latch and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_rd_len  <= '0;
      r_rd_wrap <= 1'b0;
      r_rd_cnt  <= '0;
    end else if (w_rd_accept) begin
      r_rd_addr <= bus.rd_addr;
      r_rd_len  <= bus.rd_len;
      r_rd_wrap <= bus.rd_wrap;
      r_rd_cnt  <= '0;
    end else if (w_rd_issue) begin
      r_rd_cnt <= r_rd_cnt + 8'd1;
    end
  end

  assign w_rd_beat = f_beat_addr(r_rd_addr, r_rd_len, r_rd_wrap, r_rd_cnt);

  // Combinational array read; sees pre-write contents on a same-cycle write
  always_comb begin
    w_rd_word = '0;
    for (int unsigned j = 0; j < BYTES; j++) begin
      w_rd_word[8*j +: 8] = r_mem[w_rd_beat + midx_t'(BYTES - 1 - j)];
    end
  end

  // RD_LATENCY-deep valid/last/data shift pipeline, flushed by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      r_pl <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_pv    <= RD_LATENCY'({r_pv, w_rd_issue});
      r_pl    <= RD_LATENCY'({r_pl, w_rd_issue_last});
      r_pd[0] <= w_rd_issue ? w_rd_word : '0;
      for (int unsigned i = 1; i < RD_LATENCY; i++) r_pd[i] <= r_pd[i-1];
    end
  end

  assign bus.rd_valid = r_pv[RD_LATENCY-1];
  assign bus.rd_last  = r_pl[RD_LATENCY-1];
  assign bus.rd_data  = r_pd[RD_LATENCY-1];
  assign bus.rd_busy  = w_rd_busy;

endmodule

// File: tb/tb_ram_burst_model.sv
// Directed bench for ram_burst_model: one stimulus stream drives three instances
// (RD_LATENCY 2, 1, 8); read beats are scoreboarded with data, last flag and cycle.
module tb_ram_burst_model;
  localparam int DW = 64;
  localparam int AW = 30;
  localparam int MB = 8192;
  localparam int ND = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 8;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          wr_start = 1'b0, wr_wrap = 1'b0, wr_data_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic [7:0]    wr_strb = '0;
  logic          rd_start = 1'b0, rd_wrap = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_len = '0;

  logic          o_wr_ready [ND];
  logic          o_wr_done  [ND];
  logic          o_rd_valid [ND];
  logic          o_rd_last  [ND];
  logic          o_rd_busy  [ND];
  logic [DW-1:0] o_rd_data  [ND];

  exp_t        sb [ND][$];
  logic [63:0] rexp[$];
  logic [63:0] wdat[$];
  logic [7:0]  wstrb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < ND; g++) begin : g_lat
    ram_burst_model_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if ();

    assign u_if.wr_start      = wr_start;
    assign u_if.wr_addr       = wr_addr;
    assign u_if.wr_len        = wr_len;
    assign u_if.wr_wrap       = wr_wrap;
    assign u_if.wr_data_valid = wr_data_valid;
    assign u_if.wr_data       = wr_data;
    assign u_if.wr_strb       = wr_strb;
    assign u_if.rd_start      = rd_start;
    assign u_if.rd_addr       = rd_addr;
    assign u_if.rd_len        = rd_len;
    assign u_if.rd_wrap       = rd_wrap;
    assign o_wr_ready[g]      = u_if.wr_ready;
    assign o_wr_done[g]       = u_if.wr_done;
    assign o_rd_valid[g]      = u_if.rd_valid;
    assign o_rd_last[g]       = u_if.rd_last;
    assign o_rd_busy[g]       = u_if.rd_busy;
    assign o_rd_data[g]       = u_if.rd_data;

    ram_burst_model #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_BYTES(MB), .RD_LATENCY(lat_of(g))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (u_if)
    );

    // Read monitor: every rd_valid must match the head of this instance's queue
    always @(negedge clk) begin : mon
      exp_t e;
      if (o_rd_valid[g]) begin
        if (sb[g].size() == 0) begin
          check($sformatf("L%0d_rd_valid_extra", lat_of(g)), 64'(o_rd_valid[g]), 64'd0);
        end else begin
          e = sb[g].pop_front();
          check($sformatf("L%0d_rd_data", lat_of(g)), o_rd_data[g], e.data);
          check($sformatf("L%0d_rd_last", lat_of(g)), 64'(o_rd_last[g]), 64'(e.last));
          check($sformatf("L%0d_rd_cycle", lat_of(g)), 64'(cyc), 64'(e.cyc));
        end
      end else if (sb[g].size() != 0 && sb[g][0].cyc <= cyc) begin
        check($sformatf("L%0d_rd_valid_missing", lat_of(g)), 64'(o_rd_valid[g]), 64'd1);
        void'(sb[g].pop_front());
      end
    end
  end

  task automatic push_w(input logic [63:0] d, input logic [7:0] s);
    wdat.push_back(d);
    wstrb.push_back(s);
  endtask

  task automatic push_exp(input int t0, input logic [63:0] d, input int k, input logic last);
    exp_t e;
    for (int g = 0; g < ND; g++) begin
      e.data = d;
      e.last = last;
      e.cyc  = t0 + 1 + k + lat_of(g);
      sb[g].push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < ND; g++) begin
      check($sformatf("%s_wr_ready_%0d", tag, g), 64'(o_wr_ready[g]), 64'd0);
      check($sformatf("%s_wr_done_%0d", tag, g), 64'(o_wr_done[g]), 64'd0);
      check($sformatf("%s_rd_valid_%0d", tag, g), 64'(o_rd_valid[g]), 64'd0);
      check($sformatf("%s_rd_last_%0d", tag, g), 64'(o_rd_last[g]), 64'd0);
      check($sformatf("%s_rd_busy_%0d", tag, g), 64'(o_rd_busy[g]), 64'd0);
      check($sformatf("%s_rd_data_%0d", tag, g), o_rd_data[g], 64'd0);
    end
  endtask

  // Called just after a posedge; returns just after the posedge where wr_done is high
  task automatic wr_burst(input logic [AW-1:0] a, input logic [7:0] len, input logic wrap,
                          input int gap_beat);
    wr_start = 1'b1; wr_addr = a; wr_len = len; wr_wrap = wrap;
    @(posedge clk); #1;
    wr_start = 1'b0;
    for (int g = 0; g < ND; g++) begin
      check($sformatf("wr_ready_after_start_%0d", g), 64'(o_wr_ready[g]), 64'd1);
      check($sformatf("wr_done_single_cycle_%0d", g), 64'(o_wr_done[g]), 64'd0);
    end
    for (int k = 0; k <= int'(len); k++) begin
      if (k == gap_beat) begin
        wr_data_valid = 1'b0;
        @(posedge clk); #1;
        check("wr_ready_during_gap", 64'(o_wr_ready[0]), 64'd1);
      end
      wr_data_valid = 1'b1;
      wr_data = wdat.pop_front();
      wr_strb = wstrb.pop_front();
      @(posedge clk); #1;
    end
    wr_data_valid = 1'b0;
    for (int g = 0; g < ND; g++) begin
      check($sformatf("wr_done_pulse_%0d", g), 64'(o_wr_done[g]), 64'd1);
      check($sformatf("wr_ready_drop_%0d", g), 64'(o_wr_ready[g]), 64'd0);
    end
  endtask

  // Expected beats come from rexp; optionally fires a second rd_start while busy
  task automatic rd_burst(input logic [AW-1:0] a, input logic [7:0] len, input logic wrap,
                          input bit extra_start);
    int t0;
    int span [ND];
    bit anyb;
    t0 = cyc;
    rd_start = 1'b1; rd_addr = a; rd_len = len; rd_wrap = wrap;
    for (int k = 0; k <= int'(len); k++) push_exp(t0, rexp.pop_front(), k, k == int'(len));
    @(posedge clk); #1;
    rd_start = 1'b0;
    for (int g = 0; g < ND; g++) span[g] = 0;
    for (int i = 0; i < 200; i++) begin
      rd_start = extra_start && (i == 1);
      if (rd_start) rd_addr = a + AW'(64);
      anyb = 1'b0;
      for (int g = 0; g < ND; g++) begin
        if (o_rd_busy[g]) begin
          span[g]++;
          anyb = 1'b1;
        end
      end
      if (!anyb) break;
      @(posedge clk); #1;
    end
    rd_start = 1'b0;
    for (int g = 0; g < ND; g++)
      check($sformatf("rd_busy_span_L%0d", lat_of(g)), 64'(span[g]), 64'(int'(len) + 1 + lat_of(g)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR write/read, len=3 at 0x40
    for (int i = 1; i <= 4; i++) push_w(64'(i), 8'hFF);
    wr_burst(30'h40, 8'd3, 1'b0, -1);
    for (int i = 1; i <= 4; i++) rexp.push_back(64'(i));
    rd_burst(30'h40, 8'd3, 1'b0, 1'b0);

    // Byte strobes, back-to-back single-beat writes
    push_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    push_w(64'h1122_3344_5566_7788, 8'h0F);
    wr_burst(30'h80, 8'd0, 1'b0, -1);
    wr_burst(30'h80, 8'd0, 1'b0, -1);
    check("byte_0x87", 64'(g_lat[0].u_dut.r_mem[135]), 64'h88);
    rexp.push_back(64'hFFFF_FFFF_5566_7788);
    rd_burst(30'h80, 8'd0, 1'b0, 1'b0);

    // WRAP len=3 at 0x58: window 0x40..0x5F, beats to 0x58,0x40,0x48,0x50
    push_w(64'hAAAA_0000_0000_0058, 8'hFF);
    push_w(64'hBBBB_0000_0000_0040, 8'hFF);
    push_w(64'hCCCC_0000_0000_0048, 8'hFF);
    push_w(64'hDDDD_0000_0000_0050, 8'hFF);
    wr_burst(30'h58, 8'd3, 1'b1, 2);
    rexp.push_back(64'hBBBB_0000_0000_0040);
    rexp.push_back(64'hCCCC_0000_0000_0048);
    rexp.push_back(64'hDDDD_0000_0000_0050);
    rexp.push_back(64'hAAAA_0000_0000_0058);
    rd_burst(30'h40, 8'd3, 1'b0, 1'b0);
    rexp.push_back(64'hAAAA_0000_0000_0058);
    rexp.push_back(64'hBBBB_0000_0000_0040);
    rexp.push_back(64'hCCCC_0000_0000_0048);
    rexp.push_back(64'hDDDD_0000_0000_0050);
    rd_burst(30'h58, 8'd3, 1'b1, 1'b0);
    // len+1=3 is not a legal wrap size: INCR from 0x48, plus ignored second rd_start
    rexp.push_back(64'hCCCC_0000_0000_0048);
    rexp.push_back(64'hDDDD_0000_0000_0050);
    rexp.push_back(64'hAAAA_0000_0000_0058);
    rd_burst(30'h48, 8'd2, 1'b1, 1'b1);

    // INCR wrap-around at the top of memory
    push_w(64'hEEEE_0000_0000_1FF8, 8'hFF);
    push_w(64'hFFFF_0000_0000_0000, 8'hFF);
    wr_burst(30'(MB - 8), 8'd1, 1'b0, -1);
    rexp.push_back(64'hFFFF_0000_0000_0000);
    rd_burst(30'h0, 8'd0, 1'b0, 1'b0);
    rexp.push_back(64'hEEEE_0000_0000_1FF8);
    rexp.push_back(64'hFFFF_0000_0000_0000);
    rd_burst(30'(MB - 8), 8'd1, 1'b0, 1'b0);
    rexp.push_back(64'hBBBB_0000_0000_0040);
    rd_burst(30'h2040, 8'd0, 1'b0, 1'b0);

    // Unaligned start address is aligned down
    push_w(64'h6666_0000_0000_0043, 8'hFF);
    wr_burst(30'h43, 8'd0, 1'b0, -1);
    rexp.push_back(64'h6666_0000_0000_0043);
    rd_burst(30'h47, 8'd0, 1'b0, 1'b0);

    // Same-cycle write and read of 0x40: read returns the old value
    t0 = cyc;
    wr_start = 1'b1; wr_addr = 30'h40; wr_len = 8'd0; wr_wrap = 1'b0;
    rd_start = 1'b1; rd_addr = 30'h40; rd_len = 8'd0; rd_wrap = 1'b0;
    push_exp(t0, 64'h6666_0000_0000_0043, 0, 1'b1);
    @(posedge clk); #1;
    wr_start = 1'b0; rd_start = 1'b0;
    wr_data_valid = 1'b1; wr_data = 64'h7777_0000_0000_0040; wr_strb = 8'hFF;
    @(posedge clk); #1;
    wr_data_valid = 1'b0;
    check("concurrent_wr_done", 64'(o_wr_done[0]), 64'd1);
    repeat (12) @(posedge clk);
    #1;
    rexp.push_back(64'h7777_0000_0000_0040);
    rd_burst(30'h40, 8'd0, 1'b0, 1'b0);

    // Reset in the middle of a write burst and a read burst
    t0 = cyc;
    wr_start = 1'b1; wr_addr = 30'h100; wr_len = 8'd3; wr_wrap = 1'b0;
    rd_start = 1'b1; rd_addr = 30'h40; rd_len = 8'd7; rd_wrap = 1'b0;
    push_exp(t0, 64'h7777_0000_0000_0040, 0, 1'b0);
    push_exp(t0, 64'hCCCC_0000_0000_0048, 1, 1'b0);
    @(posedge clk); #1;
    wr_start = 1'b0; rd_start = 1'b0;
    wr_data_valid = 1'b1; wr_data = 64'h1010_0000_0000_0100; wr_strb = 8'hFF;
    @(posedge clk); #1;
    wr_data = 64'h2020_0000_0000_0108;
    @(posedge clk); #1;
    wr_data_valid = 1'b0;
    check("pre_reset_rd_busy", 64'(o_rd_busy[2]), 64'd1);
    rst_n = 1'b0;
    for (int g = 0; g < ND; g++) sb[g].delete();
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    check_all_zero("held_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Partial beats survive reset; a fresh burst works afterwards
    rexp.push_back(64'h1010_0000_0000_0100);
    rexp.push_back(64'h2020_0000_0000_0108);
    rd_burst(30'h100, 8'd1, 1'b0, 1'b0);
    push_w(64'h3030_0000_0000_0110, 8'hFF);
    push_w(64'h4040_0000_0000_0118, 8'hFF);
    wr_burst(30'h110, 8'd1, 1'b0, -1);
    rexp.push_back(64'h3030_0000_0000_0110);
    rexp.push_back(64'h4040_0000_0000_0118);
    rd_burst(30'h110, 8'd1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < ND; g++)
      check($sformatf("scoreboard_drained_L%0d", lat_of(g)), 64'(sb[g].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
